// File: rtl/regfile_writeback.sv
// Write-back stage: 2-entry in-order result queue feeding the register-file write port.
// Latency: an entry accepted at edge N is presented on the write port in cycle N+1 when wp_busy=0.
// Backpressure: mem_ready = (count < 2) from registered count only; wp_busy holds the head in place.
//
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   mem_*               MEM-stage instruction offer (valid/ready handshake)
//   wp_busy             write port claimed by another writer this cycle
//   regwrite/write_reg/write_data   register-file write port (zeroed when not writing)
//   fwd_rs1/2 -> fwd_hit1/2, fwd_data1/2   combinational lookup against queued results
//   instret             retired-instruction count
//
// Optional feature: define WB_INSTRET_EN to build the instret counter;
// without it instret is tied to 0.
module regfile_writeback (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_regwrite,
    input  logic        mem_memtoreg,
    input  logic        mem_jal,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_load_data,
    input  logic [31:0] mem_pc,
    input  logic        wp_busy,
    output logic        regwrite,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    input  logic [4:0]  fwd_rs1,
    input  logic [4:0]  fwd_rs2,
    output logic        fwd_hit1,
    output logic        fwd_hit2,
    output logic [31:0] fwd_data1,
    output logic [31:0] fwd_data2,
    output logic [31:0] instret
);

    // Queue control state
    logic [1:0]  count_q, count_d;
    logic        head_q, head_d;
    logic        tail_q, tail_d;

    // Queue storage (two physical slots, indexed by head/tail pointers)
    logic [1:0]  we_q, we_d;
    logic [4:0]  rd_q   [2];
    logic [4:0]  rd_d   [2];
    logic [31:0] data_q [2];
    logic [31:0] data_d [2];

    logic        enq;
    logic        deq;
    logic        new_we;
    logic [31:0] new_data;
    logic        old_vld;
    logic        yng_vld;

    assign mem_ready = (count_q != 2'd2);
    assign enq       = mem_valid && mem_ready;
    assign deq       = (count_q != 2'd0) && !wp_busy;

    // Entry formation: link address has priority over load data.
    always_comb begin
        new_we   = (mem_regwrite || mem_jal) && (mem_rd != 5'd0);
        new_data = mem_jal      ? (mem_pc + 32'd4) :
                   mem_memtoreg ? mem_load_data    : mem_alu_result;
    end

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        we_d    = we_q;
        rd_d    = rd_q;
        data_d  = data_q;

        if (deq) begin
            head_d = ~head_q;
        end
        if (enq) begin
            we_d[tail_q]   = new_we;
            rd_d[tail_q]   = mem_rd;
            data_d[tail_q] = new_data;
            tail_d         = ~tail_q;
        end

        case ({enq, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Slot contents are only meaningful under count_q, so they need no reset.
    always_ff @(posedge clk) begin
        we_q   <= we_d;
        rd_q   <= rd_d;
        data_q <= data_d;
    end

    // Write port: driven straight from the head slot.
    always_comb begin
        regwrite   = deq && we_q[head_q];
        write_reg  = 5'd0;
        write_data = 32'd0;
        if (regwrite) begin
            write_reg  = rd_q[head_q];
            write_data = data_q[head_q];
        end
    end

    // Forwarding: head is the older entry; the other slot holds a younger
    // entry only when the queue is full, and it overrides the head on a match.
    always_comb begin
        old_vld   = (count_q != 2'd0);
        yng_vld   = (count_q == 2'd2);
        fwd_hit1  = 1'b0;
        fwd_data1 = 32'd0;
        fwd_hit2  = 1'b0;
        fwd_data2 = 32'd0;

        if (fwd_rs1 != 5'd0) begin
            if (old_vld && we_q[head_q] && (rd_q[head_q] == fwd_rs1)) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = data_q[head_q];
            end
            if (yng_vld && we_q[~head_q] && (rd_q[~head_q] == fwd_rs1)) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = data_q[~head_q];
            end
        end

        if (fwd_rs2 != 5'd0) begin
            if (old_vld && we_q[head_q] && (rd_q[head_q] == fwd_rs2)) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = data_q[head_q];
            end
            if (yng_vld && we_q[~head_q] && (rd_q[~head_q] == fwd_rs2)) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = data_q[~head_q];
            end
        end
    end

`ifdef WB_INSTRET_EN
    logic [31:0] instret_q, instret_d;

    // Every head retirement counts, including silent (we=0) entries.
    always_comb begin
        instret_d = deq ? (instret_q + 32'd1) : instret_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= 32'd0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`else
    assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus random traffic against a queue-based reference.
// Inputs are applied on the falling edge; outputs are compared 1 ns later.
// The reference retires/accepts on the rising edge from the applied inputs.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_regwrite;
    logic        mem_memtoreg;
    logic        mem_jal;
    logic [4:0]  mem_rd;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_load_data;
    logic [31:0] mem_pc;
    logic        wp_busy;
    logic        regwrite;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  fwd_rs1;
    logic [4:0]  fwd_rs2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
    logic [31:0] instret;

    always #5 clk = ~clk;

    regfile_writeback dut (
        .clk           (clk),
        .reset         (reset),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_regwrite  (mem_regwrite),
        .mem_memtoreg  (mem_memtoreg),
        .mem_jal       (mem_jal),
        .mem_rd        (mem_rd),
        .mem_alu_result(mem_alu_result),
        .mem_load_data (mem_load_data),
        .mem_pc        (mem_pc),
        .wp_busy       (wp_busy),
        .regwrite      (regwrite),
        .write_reg     (write_reg),
        .write_data    (write_data),
        .fwd_rs1       (fwd_rs1),
        .fwd_rs2       (fwd_rs2),
        .fwd_hit1      (fwd_hit1),
        .fwd_hit2      (fwd_hit2),
        .fwd_data1     (fwd_data1),
        .fwd_data2     (fwd_data2),
        .instret       (instret)
    );

    // Reference model: an in-order list of pending results.
    typedef struct {
        bit        we;
        bit [4:0]  rd;
        bit [31:0] data;
    } ent_t;

    ent_t      ref_q[$];
    bit [31:0] ref_ret;
    bit        last_acc;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_check();
        bit        e_rw;
        bit [4:0]  e_reg;
        bit [31:0] e_dat;
        bit        h1, h2;
        bit [31:0] d1, d2;
        bit [31:0] e_ret;
        e_rw  = (ref_q.size() > 0) && !wp_busy && ref_q[0].we;
        e_reg = e_rw ? ref_q[0].rd   : 5'd0;
        e_dat = e_rw ? ref_q[0].data : 32'd0;
        h1 = 0; h2 = 0; d1 = 0; d2 = 0;
        // Oldest first, so a younger match overwrites an older one.
        foreach (ref_q[i]) begin
            if (ref_q[i].we && fwd_rs1 != 0 && ref_q[i].rd == fwd_rs1) begin h1 = 1; d1 = ref_q[i].data; end
            if (ref_q[i].we && fwd_rs2 != 0 && ref_q[i].rd == fwd_rs2) begin h2 = 1; d2 = ref_q[i].data; end
        end
`ifdef WB_INSTRET_EN
        e_ret = ref_ret;
`else
        e_ret = 32'd0;
`endif
        chk("mem_ready",  {31'd0, mem_ready}, {31'd0, ref_q.size() < 2});
        chk("regwrite",   {31'd0, regwrite},  {31'd0, e_rw});
        chk("write_reg",  {27'd0, write_reg}, {27'd0, e_reg});
        chk("write_data", write_data, e_dat);
        chk("fwd_hit1",   {31'd0, fwd_hit1},  {31'd0, h1});
        chk("fwd_data1",  fwd_data1, d1);
        chk("fwd_hit2",   {31'd0, fwd_hit2},  {31'd0, h2});
        chk("fwd_data2",  fwd_data2, d2);
        chk("instret",    instret, e_ret);
    endtask

    // Apply one cycle of inputs on the falling edge, then optionally compare.
    task automatic drive(input bit rst, input bit v, input bit rw, input bit m2r, input bit jal,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] ld,
                         input logic [31:0] pc, input bit busy,
                         input logic [4:0] rs1, input logic [4:0] rs2, input bit do_chk);
        @(negedge clk);
        reset          = rst;
        mem_valid      = v;
        mem_regwrite   = rw;
        mem_memtoreg   = m2r;
        mem_jal        = jal;
        mem_rd         = rd;
        mem_alu_result = alu;
        mem_load_data  = ld;
        mem_pc         = pc;
        wp_busy        = busy;
        fwd_rs1        = rs1;
        fwd_rs2        = rs2;
        #1;
        if (do_chk) model_check();
    endtask

    task automatic idle(input bit busy, input logic [4:0] rs1, input logic [4:0] rs2);
        drive(0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, busy, rs1, rs2, 1);
    endtask

    task automatic offer(input bit rw, input bit m2r, input bit jal, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc,
                         input bit busy);
        drive(0, 1, rw, m2r, jal, rd, alu, ld, pc, busy, 5'd0, 5'd0, 1);
    endtask

    // Rising edge: update the reference from the inputs just sampled.
    task automatic tick();
        ent_t e;
        bit   rdy;
        @(posedge clk);
        last_acc = 0;
        if (reset) begin
            ref_q.delete();
            ref_ret = 0;
        end else begin
            rdy = ref_q.size() < 2;
            if (ref_q.size() > 0 && !wp_busy) begin
                void'(ref_q.pop_front());
                ref_ret = ref_ret + 1;
            end
            if (mem_valid && rdy) begin
                e.we   = (mem_regwrite || mem_jal) && (mem_rd != 0);
                e.rd   = mem_rd;
                e.data = mem_jal ? (mem_pc + 32'd4) : (mem_memtoreg ? mem_load_data : mem_alu_result);
                ref_q.push_back(e);
                last_acc = 1;
            end
        end
    endtask

    logic [4:0]  bp_rd  [3] = '{5'd3, 5'd4, 5'd6};
    logic [31:0] bp_dat [3] = '{32'hA, 32'hB, 32'hC};

    initial begin
        int pi;
        bit [31:0] ret_before;

        // Reset
        drive(1, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 5'd0, 5'd0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 5'd0, 5'd0, 0);
        tick();
        idle(0, 5'd5, 5'd0);
        chk("rst_ready", {31'd0, mem_ready}, 32'd1);
        chk("rst_regwrite", {31'd0, regwrite}, 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_fwd_hit1", {31'd0, fwd_hit1}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        tick();

        // Single ALU op
        offer(1, 0, 0, 5'd5, 32'h1234, 32'h0, 32'h100, 0);
        tick();
        idle(0, 5'd0, 5'd0);
        chk("alu_regwrite", {31'd0, regwrite}, 32'd1);
        chk("alu_reg", {27'd0, write_reg}, 32'd5);
        chk("alu_data", write_data, 32'h1234);
        chk("alu_ready", {31'd0, mem_ready}, 32'd1);
        tick();

        // JAL with PC wrap, link beats memtoreg
        offer(0, 1, 1, 5'd1, 32'h55, 32'h66, 32'hFFFF_FFFC, 0);
        tick();
        idle(0, 5'd0, 5'd0);
        chk("jal_regwrite", {31'd0, regwrite}, 32'd1);
        chk("jal_reg", {27'd0, write_reg}, 32'd1);
        chk("jal_data", write_data, 32'h0);
        tick();

        // JAL to x0: silent retirement
        ret_before = instret;
        offer(1, 0, 1, 5'd0, 32'h55, 32'h66, 32'h200, 0);
        tick();
        idle(0, 5'd0, 5'd0);
        chk("jal_x0_regwrite", {31'd0, regwrite}, 32'd0);
        tick();
        idle(0, 5'd0, 5'd0);
`ifdef WB_INSTRET_EN
        chk("jal_x0_instret", instret, ret_before + 32'd1);
`else
        chk("jal_x0_instret", instret, 32'd0);
`endif
        tick();

        // Back-pressure: 5 busy cycles while feeding three writes
        pi = 0;
        for (int c = 0; c < 10; c++) begin
            if (pi < 3)
                offer(1, 0, 0, bp_rd[pi], bp_dat[pi], 32'h0, 32'h0, c < 5);
            else
                idle(c < 5, 5'd0, 5'd0);
            if (c == 2 || c == 5) chk("bp_ready_full", {31'd0, mem_ready}, 32'd0);
            if (c >= 5 && c <= 7) begin
                chk("bp_regwrite", {31'd0, regwrite}, 32'd1);
                chk("bp_reg", {27'd0, write_reg}, {27'd0, bp_rd[c-5]});
                chk("bp_data", write_data, bp_dat[c-5]);
            end else begin
                chk("bp_idle", {31'd0, regwrite}, 32'd0);
            end
            tick();
            if (last_acc) pi++;
        end

        // Forwarding: two entries to x7, younger wins
        offer(1, 0, 0, 5'd7, 32'h11, 32'h0, 32'h0, 1);
        tick();
        offer(1, 0, 0, 5'd7, 32'h22, 32'h0, 32'h0, 1);
        tick();
        idle(1, 5'd7, 5'd0);
        chk("fwd_hit1_young", {31'd0, fwd_hit1}, 32'd1);
        chk("fwd_data1_young", fwd_data1, 32'h22);
        chk("fwd_hit2_x0", {31'd0, fwd_hit2}, 32'd0);
        chk("fwd_data2_x0", fwd_data2, 32'd0);
        tick();
        idle(0, 5'd7, 5'd7);
        tick();
        idle(0, 5'd0, 5'd0);
        tick();

        // Load select, then silent entry between two writes
        offer(1, 1, 0, 5'd9, 32'h1, 32'hDEAD_BEEF, 32'h0, 0);
        tick();
        offer(0, 0, 0, 5'd10, 32'h2, 32'h0, 32'h0, 0);
        chk("ld_data", write_data, 32'hDEAD_BEEF);
        chk("ld_reg", {27'd0, write_reg}, 32'd9);
        tick();
        offer(1, 0, 0, 5'd11, 32'h77, 32'h0, 32'h0, 0);
        chk("gap_regwrite", {31'd0, regwrite}, 32'd0);
        tick();
        idle(0, 5'd0, 5'd0);
        chk("after_gap_reg", {27'd0, write_reg}, 32'd11);
        chk("after_gap_data", write_data, 32'h77);
        tick();

        // Reset with two entries queued
        offer(1, 0, 0, 5'd12, 32'h5, 32'h0, 32'h0, 1);
        tick();
        offer(1, 0, 0, 5'd13, 32'h6, 32'h0, 32'h0, 1);
        tick();
        drive(1, 1, 1, 0, 0, 5'd14, 32'h7, 32'h0, 32'h0, 0, 5'd12, 5'd13, 1);
        tick();
        idle(0, 5'd12, 5'd13);
        chk("rst2_ready", {31'd0, mem_ready}, 32'd1);
        chk("rst2_regwrite", {31'd0, regwrite}, 32'd0);
        chk("rst2_fwd_hit1", {31'd0, fwd_hit1}, 32'd0);
        chk("rst2_instret", instret, 32'd0);
        tick();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 99) < 70),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 99) < 15),
                  5'($urandom_range(0, 7)), $urandom, $urandom,
                  (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom),
                  ($urandom_range(0, 99) < 30),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-back stage for the pipelined RISC-V core: the producer side of the register file's single write port. It accepts completed instructions from the MEM stage through a valid/ready handshake and selects each result (ALU, load data or JAL link address). It buffers up to two results in a FIFO and drains one per cycle onto the register-file write port whenever that port is not claimed by another writer. It also answers operand-forwarding lookups against results still queued.

## Interface
- No parameters. Queue depth is fixed at 2; data width is 32; register index width is 5.
- clk  in  1  core clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- mem_valid  in  1  MEM stage offers an instruction
- mem_ready  out  1  stage can accept; transfer occurs when mem_valid && mem_ready
- mem_regwrite  in  1  instruction writes rd
- mem_memtoreg  in  1  result is load data, not ALU result
- mem_jal  in  1  result is mem_pc+4 (link); overrides memtoreg, implies a write
- mem_rd  in  5  destination register
- mem_alu_result  in  32  ALU result
- mem_load_data  in  32  load data
- mem_pc  in  32  instruction PC
- wp_busy  in  1  write port claimed by another writer this cycle
- regwrite  out  1  write-port enable
- write_reg  out  5  write-port index
- write_data  out  32  write-port data
- fwd_rs1, fwd_rs2  in  5  forwarding lookup indices
- fwd_hit1, fwd_hit2  out  1  a queued entry will write that register
- fwd_data1, fwd_data2  out  32  data of the youngest matching entry
- instret  out  32  retired-instruction count (see Configuration)

## Operation
- On enqueue, the entry stores:
  - we = (mem_regwrite || mem_jal) && mem_rd != 0
  - rd
  - data = mem_jal ? mem_pc+4 (mod 2^32) : mem_memtoreg ? mem_load_data : mem_alu_result
- Entries with we=0 still occupy a slot and retire in order.
- Queue: 2 entries, in-order, head/tail pointers with a count of 0..2.
- mem_ready = (count < 2). It depends on the registered count only, so a full queue refuses a transfer even in a cycle where the head drains.
- Head drains when count > 0 && !wp_busy:
  - if head we=1: regwrite=1, write_reg=head rd, write_data=head data
  - if head we=0: retires silently with regwrite=0
- While wp_busy=1, nothing drains, regwrite=0 and the head is held.
- When regwrite=0, write_reg=0 and write_data=0.
- Enqueue and dequeue in the same cycle (count=1) leave count unchanged.
- Forwarding (combinational):
  - fwd_hitN=1 iff some valid queued entry has we=1 and rd == fwd_rsN (rsN != 0). This includes the head even in the cycle it drains.
  - When both entries match, the younger (tail-side) data wins.
  - With no hit, fwd_dataN = 0.
- Register 0 is never written and never hits.

## Timing
- Reset (synchronous, active-high) clears count/pointers and instret:
  - mem_ready=1
  - regwrite=0, write_reg=0, write_data=0
  - fwd_hit1=fwd_hit2=0, fwd_data1=fwd_data2=0
- Reset mid-operation discards queued entries without writing them. Reset has priority over enqueue and drain in the same cycle.
- Latency: an instruction transferred at edge N appears on the write port in cycle N+1 (combinational from head registers) if wp_busy=0. It is written by the register file in that cycle.
- Throughput: 1 instruction/cycle sustained while wp_busy=0.
- A wp_busy stall of k cycles fills the queue within 2 cycles; mem_ready deasserts once count=2.

## Configuration
- WB_INSTRET_EN:
  - Defined: instret increments by 1 on every head retirement (we=0 or 1) and wraps at 2^32.
  - Undefined: instret is constant 0 and the counter logic is absent.

## Test plan
- Reset then single ALU op: rd=5, alu=0x1234 at edge N → cycle N+1 regwrite=1, write_reg=5, write_data=0x1234; mem_ready stays 1.
- JAL: mem_pc=0xFFFFFFFC, rd=1, memtoreg=1 → write_data=0x00000000 (wrap, link overrides load); a JAL with rd=0 → regwrite never asserts, instret +1 (WB_INSTRET_EN).
- Back-pressure: wp_busy=1 for 5 cycles while feeding rd=3/0xA, rd=4/0xB, rd=6/0xC → mem_ready=0 after two transfers; on release, writes 3/0xA then 4/0xB on consecutive cycles, then 6/0xC.
- Forwarding: queue holds rd=7/0x11 (older) and rd=7/0x22 (younger), wp_busy=1, fwd_rs1=7, fwd_rs2=0 → fwd_hit1=1, fwd_data1=0x22, fwd_hit2=0, fwd_data2=0.
- Load select and silent entry: memtoreg=1, load=0xDEADBEEF, rd=9 → write_data=0xDEADBEEF; regwrite=0 instruction between two writes → one-cycle gap, order preserved.
- Reset with 2 entries queued → next cycle count=0, regwrite=0, mem_ready=1, instret=0.
